systolic_ctrl: RTL and testbench

Sequencer for the N x N weight-stationary PE grid. Accepts a start command, streams N weight columns into the grid under load_weight, then streams activation vectors through per-row input skew, collects bottom sums through per-column deskew, and emits aligned result vectors on a valid/ready stream. Sits between the grid and the host/DMA-side stream logic; owns the grid enable, load_weight and left-edge data.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/shift_delay.sv | 37 +++
 rtl/systolic_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer.
//   state_t   : sequencer FSM states
//   pipe_lat  : controller-visible latency from an accepted activation
//               vector to its registered result (input skew, grid hops,
//               output deskew and the result register)
//   PIPE_LAT  : pipe_lat() evaluated for the default grid size
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  function automatic int pipe_lat(input int n);
    return 2 * n - 1;
  endfunction

  localparam int N_DEF    = 4;
  localparam int PIPE_LAT = pipe_lat(N_DEF);

endpackage

// File: rtl/shift_delay.sv
// Register delay line with a common shift enable.
//   clk, reset : clock and asynchronous active-high clear
//   en         : all stages shift by one when high, hold otherwise
//   din        : value entering the line
//   dout       : value DEPTH enabled shifts old (DEPTH = 0 gives a wire)
module shift_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    // No storage: clock, reset and enable have no effect here.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en};
    assign dout        = din;
  end else begin : g_regs
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else if (en) begin
        stage[0] <= din;
        for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N weight-stationary PE grid.
//   start/num_vectors/busy/done : job command and status
//   w_data/w_valid/w_ready      : weight-column stream (N columns per job)
//   a_data/a_valid/a_ready      : activation-vector stream
//   r_data/r_valid/r_ready      : result-vector stream
//   grid_*                      : grid enable, weight-load mode, left-edge
//                                 data and bottom sums
//   dbg_state                   : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A source keeps valid and data steady until the transfer; the sink may
// change ready at any time; ready never depends on valid.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N            = 4,
  parameter int data_width   = 8,
  parameter int result_width = 32,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_vectors,
  output logic                      busy,
  output logic                      done,
  input  logic [N*data_width-1:0]   w_data,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [N*data_width-1:0]   a_data,
  input  logic                      a_valid,
  output logic                      a_ready,
  output logic [N*result_width-1:0] r_data,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic                      grid_enable,
  output logic                      grid_load_weight,
  output logic [N*data_width-1:0]   grid_inputs_left,
  input  logic [N*result_width-1:0] grid_sums_bottom,
  output logic [1:0]                dbg_state
);

  localparam int TAG_LAT = pipe_lat(N);
  localparam int WCW     = (N > 1) ? $clog2(N) : 1;
  localparam int IW      = $clog2(TAG_LAT + 1);
  localparam logic [WCW-1:0]   W_LAST  = WCW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                    state, state_nx;
  logic [WCW-1:0]            wcnt;
  logic [CNT_W-1:0]          remaining;
  logic [IW-1:0]             inflight;
  logic                      advance, a_xfer, w_xfer, tag_out;
  logic [N*data_width-1:0]   inject, skew_out;
  logic [N*result_width-1:0] deskew_out;

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx         = state;
    busy             = (state != IDLE);
    done             = 1'b0;
    w_ready          = 1'b0;
    a_ready          = 1'b0;
    grid_enable      = 1'b0;
    grid_load_weight = 1'b0;
    grid_inputs_left = '0;
    advance          = 1'b0;
    w_xfer           = 1'b0;
    a_xfer           = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nx = LOAD_W;
      end

      LOAD_W: begin
        // Weights go in unskewed; each column pushes the previous ones
        // one PE to the right.
        w_ready          = 1'b1;
        grid_load_weight = 1'b1;
        w_xfer           = w_valid;
        grid_enable      = w_valid;
        if (w_valid) grid_inputs_left = w_data;
        if (w_valid && (wcnt == W_LAST)) state_nx = COMPUTE;
      end

      COMPUTE: begin
        // The whole pipe (skew, grid, deskew, tags) moves only when the
        // result register can take a new value.
        advance          = !r_valid || r_ready;
        grid_enable      = advance;
        grid_inputs_left = skew_out;
        a_ready          = advance && (remaining != '0);
        a_xfer           = a_ready && a_valid;
        if ((remaining == '0) || (a_xfer && (remaining == CNT_ONE)))
          state_nx = DRAIN;
      end

      DRAIN: begin
        advance          = !r_valid || r_ready;
        grid_enable      = advance;
        grid_inputs_left = skew_out;
        if ((inflight == '0) && !r_valid) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Cycles without an activation transfer inject an all-zero bubble.
  assign inject = a_xfer ? a_data : '0;

  // ---------------------------------------------------------------------
  // Input skew (row i delayed i steps) and output deskew (column j
  // delayed N-1-j steps) so every element of a vector meets its column
  // partners at the grid and at the result register.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_skew
    shift_delay #(.WIDTH(data_width), .DEPTH(i)) u_skew (
      .clk   (clk),
      .reset (reset),
      .en    (advance),
      .din   (inject[i*data_width +: data_width]),
      .dout  (skew_out[i*data_width +: data_width])
    );
  end

  for (genvar j = 0; j < N; j++) begin : g_deskew
    shift_delay #(.WIDTH(result_width), .DEPTH(N - 1 - j)) u_deskew (
      .clk   (clk),
      .reset (reset),
      .en    (advance),
      .din   (grid_sums_bottom[j*result_width +: result_width]),
      .dout  (deskew_out[j*result_width +: result_width])
    );
  end

  // Valid tags: TAG_LAT-1 stages here, and r_valid is the final stage.
  shift_delay #(.WIDTH(1), .DEPTH(TAG_LAT - 1)) u_tag (
    .clk   (clk),
    .reset (reset),
    .en    (advance),
    .din   (a_xfer),
    .dout  (tag_out)
  );

  // ---------------------------------------------------------------------
  // State, counters and result register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      remaining <= '0;
      inflight  <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      state <= state_nx;

      if ((state == IDLE) && start) begin
        remaining <= num_vectors;
        wcnt      <= '0;
      end

      if (w_xfer) wcnt <= (wcnt == W_LAST) ? '0 : wcnt + WCW'(1);
      if (a_xfer) remaining <= remaining - CNT_ONE;

      if (advance) begin
        r_valid  <= tag_out;
        r_data   <= deskew_out;
        // Tags inside the delay line; the result register is tracked by
        // r_valid itself.
        inflight <= inflight + IW'(a_xfer) - IW'(tag_out);
      end
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 32;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start;
  logic [CW-1:0]     num_vectors;
  logic              busy, done;
  logic [N*DW-1:0]   w_data;
  logic              w_valid, w_ready;
  logic [N*DW-1:0]   a_data;
  logic              a_valid, a_ready;
  logic [N*RW-1:0]   r_data;
  logic              r_valid, r_ready;
  logic              grid_enable, grid_load_weight;
  logic [N*DW-1:0]   grid_inputs_left;
  logic [N*RW-1:0]   grid_sums_bottom;
  logic [1:0]        dbg_state;

  systolic_ctrl #(.N(N), .data_width(DW), .result_width(RW), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .num_vectors      (num_vectors),
    .busy             (busy),
    .done             (done),
    .w_data           (w_data),
    .w_valid          (w_valid),
    .w_ready          (w_ready),
    .a_data           (a_data),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .r_data           (r_data),
    .r_valid          (r_valid),
    .r_ready          (r_ready),
    .grid_enable      (grid_enable),
    .grid_load_weight (grid_load_weight),
    .grid_inputs_left (grid_inputs_left),
    .grid_sums_bottom (grid_sums_bottom),
    .dbg_state        (dbg_state)
  );

  // ---------------- PE grid model ----------------
  // Activation and partial sum each take one register per hop; the bottom
  // row's sum leaves the grid combinationally.
  bit [DW-1:0] g_w [N][N];
  bit [DW-1:0] g_a [N][N];
  bit [RW-1:0] g_s [N][N];
  bit [DW-1:0] act_in [N][N];
  bit [DW-1:0] w_in [N][N];
  bit [RW-1:0] psum [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      act_in[i][0] = grid_inputs_left[i*DW +: DW];
      w_in[i][0]   = grid_inputs_left[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        act_in[i][j] = g_a[i][j-1];
        w_in[i][j]   = g_w[i][j-1];
      end
    end
    for (int j = 0; j < N; j++) psum[0][j] = RW'(act_in[0][j]) * RW'(g_w[0][j]);
    for (int i = 1; i < N; i++)
      for (int j = 0; j < N; j++)
        psum[i][j] = g_s[i-1][j] + RW'(act_in[i][j]) * RW'(g_w[i][j]);
  end

  always_comb begin
    grid_sums_bottom = '0;
    for (int j = 0; j < N; j++) grid_sums_bottom[j*RW +: RW] = psum[N-1][j];
  end

  always @(posedge clk) begin
    if (grid_enable) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (grid_load_weight) g_w[i][j] <= w_in[i][j];
          else begin
            g_a[i][j] <= act_in[i][j];
            g_s[i][j] <= psum[i][j];
          end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [N*DW-1:0] wcm [N];        // weight columns of the current job
  logic [N*DW-1:0] cols [N];       // scratch column set for stimulus
  logic [N*RW-1:0] exp_q [$];
  logic [N*RW-1:0] got_q [$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, rv_cnt = 0, done_base, rv_base;
  int first_acc, first_rv;
  int rdy_mode = 0;
  logic prev_stall = 1'b0;
  logic [N*RW-1:0] prev_data;

  // Column k lands in grid column N-1-k, so result column j is the dot
  // product of the activation vector with weight column N-1-j.
  function automatic logic [N*RW-1:0] model_result(input logic [N*DW-1:0] a);
    logic [N*RW-1:0] r = '0;
    for (int j = 0; j < N; j++) begin
      int unsigned acc = 0;
      for (int i = 0; i < N; i++)
        acc += int'(a[i*DW +: DW]) * int'(wcm[N-1-j][i*DW +: DW]);
      r[j*RW +: RW] = acc;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [N*RW-1:0] act, input logic [N*RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: observes handshakes half a cycle after each edge.
  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_valid", r_valid, 1);
        check("hold_data", r_data, prev_data);
      end
      if (r_valid && !r_ready) begin
        check("stall_enable", grid_enable, 0);
        check("stall_a_ready", a_ready, 0);
      end
      if (a_valid && a_ready) begin
        exp_q.push_back(model_result(a_data));
        if (first_acc < 0) first_acc = cyc;
      end
      if (r_valid && first_rv < 0) first_rv = cyc;
      if (r_valid && r_ready) begin
        rv_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %0h expected no result at %0t", r_data, $time);
        end else begin
          check("r_data", r_data, exp_q.pop_front());
          got_q.push_back(r_data);
        end
      end
      if (done) done_cnt++;
      prev_stall = r_valid && !r_ready;
      prev_data  = r_data;
    end
  end

  // r_ready driver: 0 = always ready, 1 = random, 2 = test drives it.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) r_ready = 1'b1;
    else if (rdy_mode == 1) r_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks (start and end #1 after posedge) -----
  task automatic begin_job(input int num);
    first_acc = -1;
    first_rv  = -1;
    done_base = done_cnt;
    rv_base   = rv_cnt;
    got_q.delete();
    num_vectors = CW'(num);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_vectors = '1;   // must already be latched
    check("busy_after_start", busy, 1);
  endtask

  task automatic load_weights(input bit gap, input bit poke);
    for (int k = 0; k < N; k++) wcm[k] = cols[k];
    for (int k = 0; k < N; k++) begin
      int b = 100;
      if (gap && k == 2) begin
        w_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("gap_enable", grid_enable, 0);
          check("gap_load_mode", grid_load_weight, 1);
          @(posedge clk); #1;
        end
      end
      w_valid = 1'b1;
      w_data  = cols[k];
      if (poke && k == 1) begin
        start = 1'b1;
        num_vectors = CW'(9);
      end
      @(negedge clk);
      while (!w_ready && b > 0) begin @(negedge clk); b--; end
      if (!w_ready) fail_now("w_ready_wait");
      check("load_enable", grid_enable, 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  task automatic send_vec(input logic [N*DW-1:0] v, input int idle_after);
    int b = 300;
    a_data  = v;
    a_valid = 1'b1;
    @(negedge clk);
    while (!a_ready && b > 0) begin @(negedge clk); b--; end
    if (!a_ready) fail_now("a_ready_wait");
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_data  = '0;
    repeat (idle_after) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int b = 500;
    @(negedge clk);
    while (busy && b > 0) begin @(negedge clk); b--; end
    if (busy) fail_now("idle_wait");
    @(posedge clk); #1;
  endtask

  task automatic end_job(input int n);
    wait_idle();
    check("done_once", done_cnt - done_base, 1);
    check("result_count", rv_cnt - rv_base, n);
    check("exp_empty", exp_q.size(), 0);
  endtask

  task automatic rand_cols();
    for (int k = 0; k < N; k++) cols[k] = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_vectors = '0;
    w_data = '0; w_valid = 1'b0; a_data = '0; a_valid = 1'b0; r_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_grid_enable", grid_enable, 0);
    check("rst_load_weight", grid_load_weight, 0);
    check("rst_inputs_left", grid_inputs_left, 0);
    check("rst_r_data", r_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Identity weights: grid column j holds e_j.
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) cols[k][i*DW +: DW] = (i == N - 1 - k) ? 8'd1 : 8'd0;
    begin_job(2);
    load_weights(0, 0);
    send_vec(32'h04030201, 0);
    send_vec(32'h08070605, 0);
    end_job(2);
    check("latency", first_rv - first_acc, 2 * N - 1);
    if (got_q.size() >= 2) begin
      check("ident_vec0", got_q[0], 128'h00000004_00000003_00000002_00000001);
      check("ident_vec1", got_q[1], 128'h00000008_00000007_00000006_00000005);
    end else fail_now("ident_results");

    // All-2 weights.
    for (int k = 0; k < N; k++) cols[k] = 32'h02020202;
    begin_job(2);
    load_weights(0, 0);
    send_vec(32'h01010101, 0);
    send_vec(32'h04030201, 0);
    end_job(2);
    if (got_q.size() >= 2) begin
      check("all2_ones", got_q[0], {4{32'd8}});
      check("all2_ramp", got_q[1], {4{32'd20}});
    end else fail_now("all2_results");

    // Gapped activations: bubbles must not produce results.
    begin_job(4);
    load_weights(0, 0);
    for (int v = 0; v < 4; v++) send_vec($urandom, 1);
    end_job(4);

    // Output backpressure: 5-cycle r_ready low while results pending.
    rand_cols();
    rdy_mode = 2;
    r_ready  = 1'b1;
    begin_job(5);
    load_weights(0, 0);
    fork
      for (int v = 0; v < 5; v++) send_vec($urandom, 0);
      begin
        int b = 200;
        logic [N*RW-1:0] held;
        @(negedge clk);
        while (!r_valid && b > 0) begin @(negedge clk); b--; end
        if (!r_valid) fail_now("stall_wait");
        @(posedge clk); #1;
        r_ready = 1'b0;
        @(negedge clk);
        held = r_data;
        repeat (5) begin
          check("stall_r_valid", r_valid, 1);
          check("stall_r_data", r_data, held);
          check("stall_grid_enable", grid_enable, 0);
          check("stall_a_ready_hold", a_ready, 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        r_ready = 1'b1;
      end
    join
    end_job(5);
    rdy_mode = 0;

    // Zero-length job.
    begin_job(0);
    load_weights(0, 0);
    end_job(0);

    // start ignored in LOAD_W and DRAIN; weight-stream gap.
    for (int k = 0; k < N; k++) cols[k] = 32'h02020202;
    begin_job(1);
    load_weights(1, 1);
    send_vec(32'h01010101, 0);
    start = 1'b1;
    num_vectors = CW'(5);
    @(negedge clk);
    check("drain_busy", busy, 1);
    @(posedge clk); #1;
    start = 1'b0;
    end_job(1);
    if (got_q.size() >= 1) check("gap_weights", got_q[0], {4{32'd8}});
    else fail_now("gap_results");
    repeat (3) @(negedge clk);
    check("start_ignored", busy, 0);
    @(posedge clk); #1;

    // Reset mid-COMPUTE after 3 vectors, then a clean 1-vector job.
    rand_cols();
    begin_job(6);
    load_weights(0, 0);
    for (int v = 0; v < 3; v++) send_vec($urandom, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_r_valid", r_valid, 0);
    check("midrst_grid_enable", grid_enable, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    rand_cols();
    begin_job(1);
    load_weights(0, 0);
    send_vec($urandom, 0);
    end_job(1);

    // Random jobs with random gaps and random backpressure.
    rdy_mode = 1;
    for (int jb = 0; jb < 4; jb++) begin
      int nv = $urandom_range(1, 8);
      rand_cols();
      begin_job(nv);
      load_weights(0, 0);
      for (int v = 0; v < nv; v++) send_vec($urandom, $urandom_range(0, 2));
      end_job(nv);
    end
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
